// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises, latches and masks external lines, requests the core,
// delivers the winning vector on ack and blocks further requests until end-of-interrupt.
module irq_ctrl #(
    parameter int unsigned NUM_IRQ      = 8,
    parameter logic [15:0] SPURIOUS_NUM = 16'h00FF
) (
    input  logic               I_clk,
    input  logic               I_reset_n,
    input  logic [NUM_IRQ-1:0] I_irq_lines,
    input  logic               I_irq_ack,
    input  logic               I_eoi,
    input  logic               I_cfg_write,
    input  logic [1:0]         I_cfg_addr,
    input  logic [15:0]        I_cfg_data,
    output logic               O_irq_active,
    output logic               O_vector_valid,
    output logic [15:0]        O_irq_number,
    output logic [NUM_IRQ-1:0] O_pending,
    output logic               O_in_service
);

    localparam int unsigned NUM_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_VECTOR,
        ST_SERVICE
    } state_t;

    state_t state, next_state;

    logic [NUM_IRQ-1:0] sync1, sync2, prev;
    logic [NUM_IRQ-1:0] pending, mask, edge_mode;
    logic [NUM_IRQ-1:0] cfg_bits, rise, mask_view, clr_cfg, pend_pre, eligible;
    logic [NUM_IRQ-1:0] win_hot, ack_clr, pending_nxt;
    logic [NUM_W-1:0]   win_num, num_c;
    logic               wr_mask, wr_edge, wr_clr, take;
    logic               cfg_data_unused;

    assign cfg_bits        = I_cfg_data[NUM_IRQ-1:0];
    assign cfg_data_unused = &I_cfg_data;
    assign wr_mask         = I_cfg_write && (I_cfg_addr == 2'd0);
    assign wr_edge         = I_cfg_write && (I_cfg_addr == 2'd1);
    assign wr_clr          = I_cfg_write && (I_cfg_addr == 2'd2);

    // Eligibility sees this cycle's mask write / pending clear and fresh edges, so the
    // request leaves together with the pending bit and a racing clear can win over an ack.
    assign rise      = sync2 & ~prev;
    assign mask_view = wr_mask ? cfg_bits : mask;
    assign clr_cfg   = wr_clr ? cfg_bits : '0;
    assign pend_pre  = (edge_mode & ((pending & ~clr_cfg) | rise)) | (~edge_mode & sync2);
    assign eligible  = pend_pre & ~mask_view;

    // Lowest set index wins.
    always_comb begin
        win_hot = '0;
        win_num = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && (win_hot == '0)) begin
                win_hot[i] = 1'b1;
                win_num    = NUM_W'(i);
            end
        end
    end

    assign num_c       = (|eligible) ? win_num : SPURIOUS_NUM;
    assign ack_clr     = take ? (win_hot & edge_mode) : '0;
    assign pending_nxt = (edge_mode & ((pending & ~clr_cfg & ~ack_clr) | rise))
                       | (~edge_mode & sync2);

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            prev      <= '0;
            pending   <= '0;
            mask      <= '1;
            edge_mode <= '1;
        end else begin
            sync1   <= I_irq_lines;
            sync2   <= sync1;
            prev    <= sync2;
            pending <= pending_nxt;
            if (wr_mask) mask <= cfg_bits;
            if (wr_edge) edge_mode <= cfg_bits;
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|eligible) next_state = ST_REQUEST;
            end
            ST_REQUEST: begin
                if (I_irq_ack) begin
                    take       = 1'b1;
                    next_state = ST_VECTOR;
                end else if (!(|eligible)) begin
                    next_state = ST_IDLE;
                end
            end
            ST_VECTOR:  next_state = ST_SERVICE;
            ST_SERVICE: begin
                if (I_eoi) next_state = ST_IDLE;
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so they line up with the state register.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            O_irq_active   <= 1'b0;
            O_vector_valid <= 1'b0;
            O_irq_number   <= '0;
            O_in_service   <= 1'b0;
        end else begin
            O_irq_active   <= (next_state == ST_REQUEST);
            O_vector_valid <= (next_state == ST_VECTOR);
            O_irq_number   <= take ? num_c : '0;
            O_in_service   <= (next_state == ST_SERVICE);
        end
    end

    assign O_pending = pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, priority, masking, level mode, spurious ack, reset.
module tb_irq_ctrl;

    logic        I_clk;
    logic        I_reset_n;
    logic [7:0]  I_irq_lines;
    logic        I_irq_ack;
    logic        I_eoi;
    logic        I_cfg_write;
    logic [1:0]  I_cfg_addr;
    logic [15:0] I_cfg_data;
    logic        O_irq_active;
    logic        O_vector_valid;
    logic [15:0] O_irq_number;
    logic [7:0]  O_pending;
    logic        O_in_service;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_IRQ(8), .SPURIOUS_NUM(16'h00FF)) dut (
        .I_clk(I_clk),
        .I_reset_n(I_reset_n),
        .I_irq_lines(I_irq_lines),
        .I_irq_ack(I_irq_ack),
        .I_eoi(I_eoi),
        .I_cfg_write(I_cfg_write),
        .I_cfg_addr(I_cfg_addr),
        .I_cfg_data(I_cfg_data),
        .O_irq_active(O_irq_active),
        .O_vector_valid(O_vector_valid),
        .O_irq_number(O_irq_number),
        .O_pending(O_pending),
        .O_in_service(O_in_service)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic cfg_start(input logic [1:0] addr, input logic [15:0] data);
        I_cfg_write = 1'b1;
        I_cfg_addr  = addr;
        I_cfg_data  = data;
    endtask

    task automatic cfg_stop();
        I_cfg_write = 1'b0;
        I_cfg_addr  = 2'd0;
        I_cfg_data  = 16'h0000;
    endtask

    task automatic test_reset();
        I_reset_n = 1'b0;
        I_irq_lines = 8'h00;
        I_irq_ack = 1'b0;
        I_eoi = 1'b0;
        cfg_stop();
        tick(); tick();
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", O_irq_active); end
        checks++; if (O_vector_valid !== 1'b0) begin errors++; $display("FAIL reset_vv got %b want 0", O_vector_valid); end
        checks++; if (O_irq_number !== 16'h0000) begin errors++; $display("FAIL reset_num got %h want 0000", O_irq_number); end
        checks++; if (O_pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", O_pending); end
        checks++; if (O_in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got %b want 0", O_in_service); end
        I_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ignored();
        I_irq_ack = 1'b1; I_eoi = 1'b1;
        tick();
        I_irq_ack = 1'b0; I_eoi = 1'b0;
        checks++; if (O_vector_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_vv got %b want 0", O_vector_valid); end
        checks++; if (O_in_service !== 1'b0) begin errors++; $display("FAIL idle_eoi_insvc got %b want 0", O_in_service); end
        cfg_start(2'd3, 16'h0000);
        tick();
        cfg_stop();
        I_irq_lines = 8'h01;
        tick();
        I_irq_lines = 8'h00;
        tick(); tick();
        checks++; if (O_pending !== 8'h01) begin errors++; $display("FAIL masked_pending got %h want 01", O_pending); end
        tick();
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL reserved_addr_active got %b want 0", O_irq_active); end
        cfg_start(2'd2, 16'h0001);
        tick();
        cfg_stop();
        checks++; if (O_pending !== 8'h00) begin errors++; $display("FAIL w1c_pending got %h want 00", O_pending); end
    endtask

    task automatic test_single();
        cfg_start(2'd0, 16'h0000);
        tick();
        cfg_stop();
        I_irq_lines = 8'h08;
        tick();
        I_irq_lines = 8'h00;
        tick();
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL single_early_active got %b want 0", O_irq_active); end
        tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL single_latency_active got %b want 1", O_irq_active); end
        checks++; if (O_pending !== 8'h08) begin errors++; $display("FAIL single_pending got %h want 08", O_pending); end
        I_irq_ack = 1'b1;
        tick();
        I_irq_ack = 1'b0;
        checks++; if (O_vector_valid !== 1'b1) begin errors++; $display("FAIL single_vv got %b want 1", O_vector_valid); end
        checks++; if (O_irq_number !== 16'd3) begin errors++; $display("FAIL single_num got %h want 0003", O_irq_number); end
        checks++; if (O_pending !== 8'h00) begin errors++; $display("FAIL single_pending_clr got %h want 00", O_pending); end
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL single_vec_active got %b want 0", O_irq_active); end
        tick();
        checks++; if (O_vector_valid !== 1'b0) begin errors++; $display("FAIL single_vv_once got %b want 0", O_vector_valid); end
        checks++; if (O_in_service !== 1'b1) begin errors++; $display("FAIL single_insvc got %b want 1", O_in_service); end
        tick();
        checks++; if (O_in_service !== 1'b1) begin errors++; $display("FAIL single_insvc_hold got %b want 1", O_in_service); end
        I_eoi = 1'b1;
        tick();
        I_eoi = 1'b0;
        checks++; if (O_in_service !== 1'b0) begin errors++; $display("FAIL single_eoi got %b want 0", O_in_service); end
    endtask

    task automatic test_priority();
        I_irq_lines = 8'h24;
        tick(); tick(); tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL prio_active got %b want 1", O_irq_active); end
        checks++; if (O_pending !== 8'h24) begin errors++; $display("FAIL prio_pending got %h want 24", O_pending); end
        I_irq_ack = 1'b1;
        tick();
        I_irq_ack = 1'b0;
        checks++; if (O_irq_number !== 16'd2) begin errors++; $display("FAIL prio_first got %h want 0002", O_irq_number); end
        checks++; if (O_pending !== 8'h20) begin errors++; $display("FAIL prio_pending_left got %h want 20", O_pending); end
        tick();
        I_eoi = 1'b1;
        tick();
        I_eoi = 1'b0;
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL prio_idle_active got %b want 0", O_irq_active); end
        tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL prio_rerequest got %b want 1", O_irq_active); end
        I_irq_ack = 1'b1;
        tick();
        I_irq_ack = 1'b0;
        checks++; if (O_irq_number !== 16'd5) begin errors++; $display("FAIL prio_second got %h want 0005", O_irq_number); end
        tick();
        I_eoi = 1'b1;
        tick();
        I_eoi = 1'b0;
        I_irq_lines = 8'h00;
    endtask

    task automatic test_mask();
        cfg_start(2'd0, 16'h0004);
        tick();
        cfg_stop();
        I_irq_lines = 8'h04;
        tick();
        I_irq_lines = 8'h00;
        tick(); tick(); tick();
        checks++; if (O_pending !== 8'h04) begin errors++; $display("FAIL mask_pending got %h want 04", O_pending); end
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL mask_blocks got %b want 0", O_irq_active); end
        cfg_start(2'd0, 16'h0000);
        tick();
        cfg_stop();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL unmask_active got %b want 1", O_irq_active); end
        I_irq_ack = 1'b1;
        tick();
        I_irq_ack = 1'b0;
        checks++; if (O_irq_number !== 16'd2) begin errors++; $display("FAIL unmask_num got %h want 0002", O_irq_number); end
        tick();
        I_eoi = 1'b1;
        tick();
        I_eoi = 1'b0;
    endtask

    task automatic test_level();
        cfg_start(2'd1, 16'hFFFD);
        tick();
        cfg_stop();
        I_irq_lines = 8'h02;
        tick(); tick();
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL level_early got %b want 0", O_irq_active); end
        tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL level_active got %b want 1", O_irq_active); end
        I_irq_ack = 1'b1;
        tick();
        I_irq_ack = 1'b0;
        checks++; if (O_irq_number !== 16'd1) begin errors++; $display("FAIL level_num got %h want 0001", O_irq_number); end
        checks++; if (O_pending[1] !== 1'b1) begin errors++; $display("FAIL level_pending_kept got %b want 1", O_pending[1]); end
        tick();
        I_eoi = 1'b1;
        tick();
        I_eoi = 1'b0;
        tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL level_rerequest got %b want 1", O_irq_active); end
        I_irq_lines = 8'h00;
        tick(); tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL level_hold got %b want 1", O_irq_active); end
        tick();
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL level_drop_active got %b want 0", O_irq_active); end
        checks++; if (O_pending[1] !== 1'b0) begin errors++; $display("FAIL level_drop_pending got %b want 0", O_pending[1]); end
        cfg_start(2'd1, 16'hFFFF);
        tick();
        cfg_stop();
    endtask

    task automatic test_spurious();
        I_irq_lines = 8'h10;
        tick();
        I_irq_lines = 8'h00;
        tick(); tick();
        checks++; if (O_irq_active !== 1'b1) begin errors++; $display("FAIL spur_active got %b want 1", O_irq_active); end
        I_irq_ack = 1'b1;
        cfg_start(2'd2, 16'h0010);
        tick();
        I_irq_ack = 1'b0;
        cfg_stop();
        checks++; if (O_vector_valid !== 1'b1) begin errors++; $display("FAIL spur_vv got %b want 1", O_vector_valid); end
        checks++; if (O_irq_number !== 16'h00FF) begin errors++; $display("FAIL spur_num got %h want 00ff", O_irq_number); end
        checks++; if (O_pending !== 8'h00) begin errors++; $display("FAIL spur_pending got %h want 00", O_pending); end
        tick();
        I_eoi = 1'b1;
        tick();
        I_eoi = 1'b0;
    endtask

    task automatic test_service_reset();
        I_irq_lines = 8'h40;
        tick();
        I_irq_lines = 8'h00;
        tick(); tick();
        I_irq_ack = 1'b1;
        tick();
        I_irq_ack = 1'b0;
        checks++; if (O_irq_number !== 16'd6) begin errors++; $display("FAIL svc_num got %h want 0006", O_irq_number); end
        tick();
        checks++; if (O_in_service !== 1'b1) begin errors++; $display("FAIL svc_insvc got %b want 1", O_in_service); end
        I_irq_ack = 1'b1;
        I_irq_lines = 8'h01;
        tick();
        I_irq_ack = 1'b0;
        I_irq_lines = 8'h00;
        checks++; if (O_vector_valid !== 1'b0) begin errors++; $display("FAIL svc_ack_ignored got %b want 0", O_vector_valid); end
        tick(); tick();
        checks++; if (O_pending !== 8'h01) begin errors++; $display("FAIL svc_pending_held got %h want 01", O_pending); end
        checks++; if (O_in_service !== 1'b1) begin errors++; $display("FAIL svc_still got %b want 1", O_in_service); end
        checks++; if (O_irq_active !== 1'b0) begin errors++; $display("FAIL svc_no_request got %b want 0", O_irq_active); end
        #3;
        I_reset_n = 1'b0;
        #1;
        checks++; if (O_in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc got %b want 0", O_in_service); end
        checks++; if (O_pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %h want 00", O_pending); end
        checks++; if (O_irq_active !== 1'b0 || O_vector_valid !== 1'b0 || O_irq_number !== 16'h0000) begin
            errors++; $display("FAIL rst_outputs got %b %b %h want 0 0 0000", O_irq_active, O_vector_valid, O_irq_number);
        end
        tick();
        I_reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_ignored();
        test_single();
        test_priority();
        test_mask();
        test_level();
        test_spurious();
        test_service_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Interrupt controller directly upstream of the core. It collects up to NUM_IRQ external interrupt lines, latches and masks them, and raises a single request toward the core. On the core's acknowledge it presents the winning interrupt number on the data bus for exactly one cycle. It then holds off further requests until the ISR signals end-of-interrupt (RETI).

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..16); source 0 has highest priority.
SPURIOUS_NUM, 16'h00FF, number returned when an ack arrives with nothing pending.

Ports:
I_clk  input  1  system clock
I_reset_n  input  1  reset, asynchronous, active-low
I_irq_lines  input  NUM_IRQ  raw interrupt sources, asynchronous to I_clk
I_irq_ack  input  1  acknowledge from core (core O_irq_ack), may be multi-cycle high
I_eoi  input  1  one-cycle pulse, end of ISR (core executing RETI)
I_cfg_write  input  1  configuration write strobe
I_cfg_addr  input  2  0=mask, 1=edge_mode, 2=pending clear (write-1-to-clear)
I_cfg_data  input  16  configuration write data, bits [NUM_IRQ-1:0] used
O_irq_active  output  1  request to core (core I_irq_active)
O_vector_valid  output  1  high for the single cycle O_irq_number is valid
O_irq_number  output  16  interrupt number, zero-extended; drives the core data bus when O_vector_valid
O_pending  output  NUM_IRQ  current pending register (status)
O_in_service  output  1  high from vector delivery until EOI

Behaviour:
- Reset (async, I_reset_n=0): pending=0, mask=all 1 (all masked), edge_mode=all 1, sync flops=0, state=IDLE. All outputs 0.
- Input sync: each line goes through 2 flops, then a prev flop. Edge mode: rising edge of the synced line sets pending. Level mode: pending = synced line (no latching).
- Eligible = pending & ~mask. winner = lowest index set in eligible.
- FSM states:
  - IDLE: O_irq_active=0. Eligible!=0 → REQUEST (next cycle).
  - REQUEST: O_irq_active=1. On I_irq_ack=1: latch winner (or SPURIOUS_NUM if eligible became 0), clear pending[winner] if that source is edge mode → VECTOR. If eligible drops to 0 without an ack → IDLE.
  - VECTOR: exactly one cycle. O_vector_valid=1, O_irq_number=latched value, O_irq_active=0 → SERVICE.
  - SERVICE: O_in_service=1, O_irq_active=0. Ignores I_irq_ack. On I_eoi → IDLE. No nesting.
- Latency: the ack is sampled at edge k. O_irq_number is registered and valid throughout cycle k..k+1, so the core samples it at edge k+1. Requirement: the first rising edge of a source reaches O_irq_active 3 cycles later (2 sync + pending).
- Simultaneous events:
  - A new edge on the source being cleared in the same cycle: the set wins, and pending stays 1.
  - A config pending-clear together with an edge set: the set wins.
  - I_eoi outside SERVICE: ignored.
  - I_irq_ack in IDLE: ignored.
- Config: writes take effect at the next edge. Changing the mask in REQUEST re-evaluates eligible that cycle. A mask write does not alter pending. addr 3 is reserved (write ignored).
- Bits ≥ NUM_IRQ of O_irq_number are always 0, except when SPURIOUS_NUM is returned.
- Reset asserted mid-service: immediate return to reset state; pending history is lost.

Test Plan:
- Reset, unmask all (mask=0), pulse line 3 for 1 cycle → O_irq_active high 3 cycles later. Ack 1 cycle → next cycle O_vector_valid=1, O_irq_number=3, pending[3]=0. Then O_in_service=1 until I_eoi.
- Lines 5 and 2 rise in the same cycle → first vector is 2. After EOI, O_irq_active reasserts and vector 5 is delivered.
- mask=16'h0004, line 2 pulses → no request. Write mask=0 → request appears next cycle, vector 2.
- Line 1 in level mode (edge_mode=16'hFFFD) held high → vector 1. After EOI, re-requests immediately. Drop line → after sync, O_irq_active=0 and pending[1]=0.
- In REQUEST with only line 4 pending, pending-clear write 16'h0010 lands at the same edge as the ack → vector is SPURIOUS_NUM (16'h00FF).
- In SERVICE, pulse I_irq_ack again and pulse line 0 → no new vector. pending[0]=1 is held. Async reset mid-SERVICE → all outputs 0 immediately, pending=0.
